// File: rtl/div_radix2.sv
// Iterative restoring radix-2 integer divider, signed/unsigned, with RV64 word ops.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_radix2 #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_flush,
    input  logic            div_valid,
    output logic            div_i_ready,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_o_valid,
    input  logic            div_o_ready
);

    localparam int CW  = $clog2(XLEN);
    localparam int WSH = (XLEN > 32) ? 32 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_b;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_word;
    logic [XLEN-1:0] r_quotient;
    logic [XLEN-1:0] r_remainder;

    logic            w_word;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_min;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_early;
    logic            w_special;
    logic            w_accept;
    logic            w_last;

    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;

    // Word results are always sign-extended from bit 31.
    function automatic logic [XLEN-1:0] fmt(
        input logic [XLEN-1:0] v,
        input logic            w
    );
        return w ? XLEN'($signed(v[31:0])) : v;
    endfunction

    // Operand extension, magnitudes and special-case detection at accept time
    always_comb begin
        w_word  = (XLEN == 64) && div_word;
        w_a_ext = dividend;
        w_b_ext = divisor;
        if (w_word) begin
            w_a_ext = div_signed ? XLEN'($signed(dividend[31:0]))
                                 : XLEN'(dividend[31:0]);
            w_b_ext = div_signed ? XLEN'($signed(divisor[31:0]))
                                 : XLEN'(divisor[31:0]);
        end
        w_a_neg  = div_signed & w_a_ext[XLEN-1];
        w_b_neg  = div_signed & w_b_ext[XLEN-1];
        w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
        w_min    = w_word ? ~XLEN'(32'h7FFF_FFFF)
                          : {1'b1, {(XLEN-1){1'b0}}};
        w_b_zero = (w_b_ext == '0);
        w_ovf    = div_signed && (w_a_ext == w_min) && (w_b_ext == '1);
    end

`ifdef DIV_EARLY_OUT_EN
    assign w_early = !w_b_zero && (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    assign w_special = w_b_zero | w_ovf | w_early;
    assign w_accept  = (r_state == S_IDLE) && div_valid && !div_flush;
    assign w_last    = (r_cnt == (r_word ? CW'(31) : CW'(XLEN-1)));

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        w_rem_sh   = {r_rem, r_quo[XLEN-1]};
        w_diff     = w_rem_sh - {1'b0, r_b};
        w_qbit     = !w_diff[XLEN];
        w_rem_next = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        w_quo_next = {r_quo[XLEN-2:0], w_qbit};
        w_q_fin    = fmt(r_neg_q ? -w_quo_next : w_quo_next, r_word);
        w_r_fin    = fmt(r_neg_r ? -w_rem_next : w_rem_next, r_word);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; flush wins over accept and the result handshake
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (div_flush)   w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (div_flush || div_o_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        div_i_ready = (r_state == S_IDLE);
        div_o_valid = (r_state == S_DONE);
        quotient    = r_quotient;
        remainder   = r_remainder;
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_b         <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_word      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_quo   <= w_word ? (w_a_mag << WSH) : w_a_mag;
                r_b     <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_word  <= w_word;
                if (w_b_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= fmt(w_a_ext, w_word);
                end else if (w_ovf) begin
                    r_quotient  <= fmt(w_a_ext, w_word);
                    r_remainder <= '0;
                end else if (w_early) begin
                    r_quotient  <= '0;
                    r_remainder <= fmt(w_a_ext, w_word);
                end
            end else if (r_state == S_CALC && !div_flush) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_quotient  <= w_q_fin;
                    r_remainder <= w_r_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2 (XLEN=64): directed vectors, latency,
// hold/flush/reset behaviour.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_flush = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_i_ready;
    logic        div_signed = 1'b0;
    logic        div_word = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_o_valid;
    logic        div_o_ready = 1'b1;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 65;
`endif

    div_radix2 #(.XLEN(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_flush   (div_flush),
        .div_valid   (div_valid),
        .div_i_ready (div_i_ready),
        .div_signed  (div_signed),
        .div_word    (div_word),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_o_valid (div_o_valid),
        .div_o_ready (div_o_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares latency on first valid, results on handshake
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && div_o_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 64'(div_o_valid), 64'd0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk({"lat_", sb[0].nm}, 64'(cyc - sb[0].acc),
                            64'(sb[0].lat));
                    end
                    if (div_o_ready) begin
                        e = sb.pop_front();
                        seen = 1'b0;
                        chk({"quo_", e.nm}, quotient, e.q);
                        chk({"rem_", e.nm}, remainder, e.r);
                    end
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [63:0] a,
                         input logic [63:0] b, input bit s, input bit w,
                         input logic [63:0] eq, input logic [63:0] er,
                         input int lat, input bit push);
        exp_t e;
        int   t;
        t = 0;
        while (!div_i_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk({"idle_timeout_", nm}, 64'(div_i_ready), 64'd1);
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_word   = w;
        div_valid  = 1'b1;
        if (push) begin
            e.q = eq; e.r = er; e.lat = lat; e.acc = cyc; e.nm = nm;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        div_valid  = 1'b0;
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
        div_signed = ~s;
        div_word   = ~w;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !div_i_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_i_ready", 64'(div_i_ready), 64'd1);
        chk("rst_o_valid", 64'(div_o_valid), 64'd0);
        chk("rst_quo", quotient, 64'd0);
        chk("rst_rem", remainder, 64'd0);

        issue("u100_7", 64'd100, 64'd7, 0, 0, 64'd14, 64'd2, 65, 1);
        drain();
        issue("sw_m7_2", 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 1, 1,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1);
        drain();
        issue("s_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              1, 0, 64'h8000_0000_0000_0000, 64'd0, 1, 1);
        drain();
        issue("u5_0", 64'd5, 64'd0, 0, 0, '1, 64'd5, 1, 1);
        drain();
        issue("s_m100_7", -64'd100, 64'd7, 1, 0, -64'd14, -64'd2, 65, 1);
        drain();
        issue("s_100_m7", 64'd100, -64'd7, 1, 0, -64'd14, 64'd2, 65, 1);
        drain();
        issue("s_m7_m2", -64'd7, -64'd2, 1, 0, 64'd3, -64'd1, 65, 1);
        drain();
        issue("uw_ffff_1", 64'h1234_5678_FFFF_FFFF, 64'd1, 0, 1,
              '1, 64'd0, 33, 1);
        drain();
        issue("sw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              1, 1, 64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1);
        drain();
        issue("u3_9", 64'd3, 64'd9, 0, 0, 64'd0, 64'd3, EO_LAT, 1);
        drain();
        issue("u_big_16", '1, 64'd16, 0, 0, 64'h0FFF_FFFF_FFFF_FFFF,
              64'd15, 65, 1);
        drain();

        // Consumer stall: results must hold while o_ready is low
        div_o_ready = 1'b0;
        issue("hold_1000_3", 64'd1000, 64'd3, 0, 0, 64'd333, 64'd1, 65, 1);
        t = 0;
        while (!div_o_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("hold_o_valid", 64'(div_o_valid), 64'd1);
            chk("hold_i_ready", 64'(div_i_ready), 64'd0);
            chk("hold_quo", quotient, 64'd333);
            chk("hold_rem", remainder, 64'd1);
            @(posedge clk); #1;
        end
        div_o_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_i_ready", 64'(div_i_ready), 64'd1);
        chk("release_o_valid", 64'(div_o_valid), 64'd0);
        drain();

        // Flush mid-calculation, then a fresh op
        issue("flushed", 64'd1_000_000, 64'd3, 0, 0, '0, '0, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        chk("flush_i_ready", 64'(div_i_ready), 64'd1);
        chk("flush_o_valid", 64'(div_o_valid), 64'd0);
        issue("after_flush", 64'd1000, 64'd10, 0, 0, 64'd100, 64'd0, 65, 1);
        drain();

        // Reset mid-calculation clears everything
        issue("reset_op", 64'd77, 64'd5, 0, 0, '0, '0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_o_valid", 64'(div_o_valid), 64'd0);
        chk("mrst_quo", quotient, 64'd0);
        chk("mrst_rem", remainder, 64'd0);
        rst_n = 1'b1;
        chk("mrst_i_ready", 64'(div_i_ready), 64'd1);
        issue("after_rst", 64'd77, 64'd5, 0, 0, 64'd15, 64'd2, 65, 1);
        drain();

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
